// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register.
// Holds the occupancy state encoding and the NOP / flush payload
// that every stage instance falls back to by default.
package pipe_pkg;

    // Occupancy of a stage register, encoded as the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_e;

    // Default payload for an empty or flushed entry.
    // All-zero bits decode as a NOP in the datapaths this register serves.
    localparam logic [63:0] PIPE_NOP = 64'h0;

    // Number of entries held for a given main/skid valid pair.
    function automatic logic [1:0] occ_of(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_stat_counter.sv
// Saturating event counter used for the stage statistics.
// Counts cycles where inc is high; sticks at all-ones and clears only on rst.
module pipe_stat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: advance on inc unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake and a
// two-entry skid buffer (main + skid), plus flush and freeze controls.
// in_ready is derived from registered state and freeze/flush only, so no
// combinational path runs from out_ready back to in_ready.
// Optional statistics counters are built when PIPE_STAGE_REG_STATS_EN is
// defined; otherwise the counter ports are tied to zero.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  FLUSH_VAL = DATA_W'(PIPE_NOP),
    parameter int                 CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    occ_e              state_q;
    occ_e              state_d;
    logic [DATA_W-1:0] main_data_q;
    logic [DATA_W-1:0] main_data_d;
    logic [DATA_W-1:0] skid_data_q;
    logic [DATA_W-1:0] skid_data_d;

    logic main_valid;
    logic skid_valid;
    logic in_fire;
    logic out_fire;

    // The state encoding is the entry count, so the valids fall out of it.
    assign main_valid = (state_q != ST_EMPTY);
    assign skid_valid = (state_q == ST_TWO);

    assign in_ready  = ~skid_valid & ~freeze & ~flush;
    assign out_valid =  main_valid & ~freeze & ~flush;
    assign in_fire   = in_valid  & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Invalid entries already hold FLUSH_VAL; the mux keeps out_data
    // well-defined even if that invariant were ever broken.
    assign out_data  = main_valid ? main_data_q : FLUSH_VAL;
    assign occupancy = occ_of(main_valid, skid_valid);

    // Next-state and payload selection; flush beats freeze beats handshake.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            main_data_d = FLUSH_VAL;
            skid_data_d = FLUSH_VAL;
        end else if (!freeze) begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d     = ST_ONE;
                        main_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        // Pass-through: the new word replaces the departing one.
                        main_data_d = in_data;
                    end else if (in_fire) begin
                        // Downstream stalled this cycle; park the word in skid.
                        state_d     = ST_TWO;
                        skid_data_d = in_data;
                    end else if (out_fire) begin
                        state_d     = ST_EMPTY;
                        main_data_d = FLUSH_VAL;
                    end
                end
                ST_TWO: begin
                    // Full: in_ready is low, only draining is possible.
                    if (out_fire) begin
                        state_d     = ST_ONE;
                        main_data_d = skid_data_q;
                        skid_data_d = FLUSH_VAL;
                    end
                end
                default: begin
                    // Unused encoding: recover to a clean empty register.
                    state_d     = ST_EMPTY;
                    main_data_d = FLUSH_VAL;
                    skid_data_d = FLUSH_VAL;
                end
            endcase
        end
    end

    // Occupancy FSM and payload registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_data_q <= FLUSH_VAL;
            skid_data_q <= FLUSH_VAL;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

`ifdef PIPE_STAGE_REG_STATS_EN
    // Index 0: stall, 1: bubble, 2: flush of a non-empty register.
    logic [2:0]       stat_inc;
    logic [CNT_W-1:0] stat_cnt [3];

    assign stat_inc[0] =  main_valid & (freeze | ~out_ready);
    assign stat_inc[1] = ~main_valid & out_ready & ~freeze;
    assign stat_inc[2] =  flush & (state_q != ST_EMPTY);

    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
        pipe_stat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (stat_inc[gi]),
            .count (stat_cnt[gi])
        );
    end

    assign stall_cnt  = stat_cnt[0];
    assign bubble_cnt = stat_cnt[1];
    assign flush_cnt  = stat_cnt[2];
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
    assign flush_cnt  = '0;
`endif

endmodule
